sa_tile_engine: RTL
===================

SA_TILE_ENGINE -- requirements
Module: sa_tile_engine

Interface
REQ-001 SHALL have parameter N, default 8: array is N x N processing elements.
REQ-002 SHALL have parameter DW, default 8: operand width in bits.
REQ-003 SHALL have parameter KMAX, default 256: maximum accumulation depth.
REQ-004 SHALL have parameter AW, default 2*DW+$clog2(KMAX): accumulator width in bits.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request a new tile; accepted only in IDLE.
REQ-008 SHALL have port k_len, input, $clog2(KMAX+1): number of k beats; sampled on start.
REQ-009 SHALL have port signed_mode, input, 1: 1 = two's-complement operands; sampled on start.
REQ-010 SHALL have port in_valid, input, 1: a_col/b_row carry one k beat.
REQ-011 SHALL have port in_ready, output, 1: high only in LOAD.
REQ-012 SHALL have port a_col, input, [N][DW]: A[i][k] for row i.
REQ-013 SHALL have port b_row, input, [N][DW]: B[k][j] for column j.
REQ-014 SHALL have port busy, output, 1: high in LOAD and DRAIN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse; c_out valid from this cycle.
REQ-016 SHALL have port c_out, output, [N][N][AW]: C[i][j] = sum over k of A[i][k]*B[k][j].

Function
REQ-017 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-018 IDLE: on start, SHALL latch k_len and signed_mode, clear all accumulators, go to LOAD; k_len==0 SHALL go to DONE instead.
REQ-019 k_len values above KMAX SHALL be treated as KMAX.
REQ-020 A beat SHALL be accepted when in_valid && in_ready; LOAD SHALL exit to DRAIN in the cycle after the K-th accepted beat.
REQ-021 The array SHALL advance every cycle; a cycle without an accepted beat SHALL inject zero operands into both edges.
REQ-022 Skew: a_col[i] SHALL be delayed i cycles and b_row[j] delayed j cycles before entering the array edge.
REQ-023 Each PE SHALL multiply-accumulate its inputs, then pass a right and b down through one register each.
REQ-024 DRAIN SHALL last exactly 2N-1 cycles, then go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 Latency with no stalls: start accepted at cycle t0 SHALL give done at t0+K+2N; each stalled LOAD cycle SHALL add one cycle.
REQ-027 Products SHALL be sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to AW; accumulation SHALL wrap modulo 2^AW.
REQ-028 c_out SHALL hold its value after DONE until the next accepted start.
REQ-029 start while not in IDLE SHALL be ignored; a beat presented outside LOAD SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, clear accumulators, skew and pipeline registers, set busy=in_ready=done=0 and c_out=0.
REQ-031 rst asserted in any state, including mid-LOAD or DRAIN, SHALL abort the tile with no done pulse.

Structure
REQ-032 Package sa_pkg SHALL hold the state enum, default parameter values, and the AW default-width function.
REQ-033 Sub-module sa_mac_pe SHALL implement one PE (MAC, signed/unsigned select, pass-through registers, clear); the top SHALL instantiate N*N of them via generate.

Verification (N=4, DW=8, KMAX=256)
REQ-034 Identity test: A=I4, B[k][j]=4k+j, K=4, in_valid held high -> c_out=B; done at t0+12; busy high t0+1..t0+11.
REQ-035 Sign-mode test: all a=0xFF, all b=0x02, K=3 -> signed: every C=-6 (0xFFFFFA); unsigned: every C=1530.
REQ-036 Stall test: the identity test with in_valid toggling 1,0,1,0,... -> identical c_out; done 3 cycles later (t0+15).
REQ-037 Full-depth test: all a=b=0xFF, unsigned, K=256 -> every C=16646400 with no wrap; done at t0+264.
REQ-038 Reset/control test: rst mid-LOAD -> IDLE, c_out=0, no done; then k_len=0 start -> done at t0+1 with all-zero c_out; start during busy ignored; c_out held through IDLE.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg -- shared definitions for the systolic-array tile engine.
//   state_e     : tile controller states
//   *_DEF       : default array size, operand width and accumulation depth
//   aw_default  : accumulator width that holds KMAX full-scale products
package sa_pkg;

    localparam int N_DEF    = 8;
    localparam int DW_DEF   = 8;
    localparam int KMAX_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // 2*DW bits per product plus log2(KMAX) bits of accumulation growth.
    function automatic int aw_default(input int dw, input int kmax);
        return 2 * dw + $clog2(kmax);
    endfunction

endpackage

// File: rtl/sa_tile_engine_if.sv
// sa_tile_engine_if -- control, operand stream and result bus of the tile engine.
//   start/k_len/signed_mode : tile request (sampled in IDLE)
//   in_valid/in_ready       : one k beat of a_col (A column) and b_row (B row)
//   busy/done/c_out         : status and the N x N result matrix
// master = tile producer/consumer, slave = engine.
interface sa_tile_engine_if
    import sa_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int KMAX = KMAX_DEF,
    parameter int AW   = aw_default(DW, KMAX)
);
    logic                            start;
    logic [$clog2(KMAX+1)-1:0]       k_len;
    logic                            signed_mode;
    logic                            in_valid;
    logic                            in_ready;
    logic [N-1:0][DW-1:0]            a_col;
    logic [N-1:0][DW-1:0]            b_row;
    logic                            busy;
    logic                            done;
    logic [N-1:0][N-1:0][AW-1:0]     c_out;

    modport master (
        output start, k_len, signed_mode, in_valid, a_col, b_row,
        input  in_ready, busy, done, c_out
    );

    modport slave (
        input  start, k_len, signed_mode, in_valid, a_col, b_row,
        output in_ready, busy, done, c_out
    );
endinterface

// File: rtl/sa_mac_pe.sv
// sa_mac_pe -- one processing element of the systolic array.
//   clear_i  : zero the accumulator (takes priority over accumulation)
//   signed_i : 1 = two's-complement operands, 0 = unsigned
//   a_i/b_i  : operands from the left/top neighbour
//   a_o/b_o  : operands registered for the right/bottom neighbour
//   acc_o    : running sum, wraps modulo 2^AW
module sa_mac_pe #(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          signed_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [AW-1:0] acc_o
);
    localparam int PW = 2 * DW;

    logic signed [PW-1:0] prod_s;
    logic        [PW-1:0] prod_u;
    logic        [AW-1:0] prod_ext;
    logic        [AW-1:0] acc_d, acc_q;
    logic        [DW-1:0] a_q, b_q;

    always_comb begin
        // Operands are widened before multiplying so the product is full width.
        prod_s = PW'($signed(a_i)) * PW'($signed(b_i));
        prod_u = PW'(a_i) * PW'(b_i);
        if (signed_i) prod_ext = AW'(prod_s);   // sign-extends
        else          prod_ext = AW'(prod_u);   // zero-extends
        acc_d = clear_i ? '0 : acc_q + prod_ext;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_i;
            b_q   <= b_i;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/sa_tile_engine.sv
// sa_tile_engine -- N x N output-stationary systolic array computing C = A * B.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : sa_tile_engine_if.slave (request, k-beat stream, status, c_out)
// A tile streams K beats (column k of A, row k of B); idle cycles inject zeros.
// After the last beat the array drains for 2N-1 cycles, then done pulses.
module sa_tile_engine
    import sa_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int KMAX = KMAX_DEF,
    parameter int AW   = aw_default(DW, KMAX)
) (
    input  logic            clk,
    input  logic            rst,
    sa_tile_engine_if.slave bus
);
    localparam int KW  = $clog2(KMAX + 1);
    localparam int DCW = $clog2(2 * N);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_rem_q, k_rem_d;   // beats still to accept
    logic [DCW-1:0]   drain_q, drain_d;   // drain cycles left after this one
    logic             signed_q, signed_d;
    logic             clear;
    logic             accept;

    logic [DW-1:0] a_inj  [N];
    logic [DW-1:0] b_inj  [N];
    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic [DW-1:0] a_pipe [N][N];
    logic [DW-1:0] b_pipe [N][N];
    logic [AW-1:0] acc    [N][N];

    assign accept = bus.in_valid && (state_q == ST_LOAD);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        k_rem_d  = k_rem_q;
        drain_d  = drain_q;
        signed_d = signed_q;
        clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear    = 1'b1;
                    signed_d = bus.signed_mode;
                    k_rem_d  = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
                    state_d  = (bus.k_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    k_rem_d = k_rem_q - KW'(1);
                    if (k_rem_q == KW'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = DCW'(2 * N - 2);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DCW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_rem_q  <= '0;
            drain_q  <= '0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_rem_q  <= k_rem_d;
            drain_q  <= drain_d;
            signed_q <= signed_d;
        end
    end

    assign bus.in_ready = (state_q == ST_LOAD);
    assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign bus.done     = (state_q == ST_DONE);

    // Unaccepted cycles feed zeros so the array can advance unconditionally.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = accept ? bus.a_col[i] : '0;
            b_inj[i] = accept ? bus.b_row[i] : '0;
        end
    end

    // Row i / column i enters i cycles late so matching k terms meet in each PE.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_inj[i];
            assign b_edge[i] = b_inj[i];
        end else begin : g_dly
            logic [i-1:0][DW-1:0] a_sr_q, b_sr_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_sr_q <= '0;
                    b_sr_q <= '0;
                end else begin
                    a_sr_q[0] <= a_inj[i];
                    b_sr_q[0] <= b_inj[i];
                    for (int s = 1; s < i; s++) begin
                        a_sr_q[s] <= a_sr_q[s-1];
                        b_sr_q[s] <= b_sr_q[s-1];
                    end
                end
            end
            assign a_edge[i] = a_sr_q[i-1];
            assign b_edge[i] = b_sr_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DW-1:0] a_in, b_in;
            if (j == 0) begin : g_a_edge
                assign a_in = a_edge[i];
            end else begin : g_a_int
                assign a_in = a_pipe[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_int
                assign b_in = b_pipe[i-1][j];
            end
            sa_mac_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clear_i  (clear),
                .signed_i (signed_q),
                .a_i      (a_in),
                .b_i      (b_in),
                .a_o      (a_pipe[i][j]),
                .b_o      (b_pipe[i][j]),
                .acc_o    (acc[i][j])
            );
        end
    end

    // Accumulators are the result; they hold until the next start clears them.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                bus.c_out[i][j] = acc[i][j];
            end
        end
    end
endmodule
